// File: rtl/sigmoid_bwd_pkg.sv
// Shared fixed-point constants and FSM encoding for the sigmoid backward unit.
// Optional rounding is selected with the SIGMOID_BWD_ROUND_EN macro.
package sigmoid_bwd_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned FL    = 24;

    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1) << FL;
    localparam logic [WIDTH-1:0] ZERO       = '0;
    localparam logic [WIDTH-1:0] ROUND_HALF = WIDTH'(1) << (FL - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul1 = 2'd1,
        StMul2 = 2'd2,
        StOut  = 2'd3
    } state_e;

endpackage

// File: rtl/sigmoid_bwd_if.sv
// Valid/ready request and response channels of the sigmoid backward unit.
// The slave modport is the datapath side; the master modport is the driver side.
interface sigmoid_bwd_if
    import sigmoid_bwd_pkg::*;
#(
    parameter int unsigned WIDTH = sigmoid_bwd_pkg::WIDTH
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] y_in;
    logic signed [WIDTH-1:0] g_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] d_out;

    modport slave (
        input  in_valid,
        output in_ready,
        input  y_in,
        input  g_in,
        output out_valid,
        input  out_ready,
        output d_out
    );

    modport master (
        output in_valid,
        input  in_ready,
        output y_in,
        output g_in,
        input  out_valid,
        output out_ready,
        input  d_out
    );
endinterface

// File: rtl/sigmoid_bwd_fx_mul.sv
// Combinational signed Q-format multiply, keeping bits [FL+WIDTH-1:FL] of the product.
// With SIGMOID_BWD_ROUND_EN defined, half an LSB is added before slicing (round half up).
module sigmoid_bwd_fx_mul
    import sigmoid_bwd_pkg::*;
#(
    parameter int unsigned WIDTH = sigmoid_bwd_pkg::WIDTH,
    parameter int unsigned FL    = sigmoid_bwd_pkg::FL
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] p_o
);
    localparam int unsigned PW = 2 * WIDTH;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_adj;
    logic                 unused_prod_bits;

    assign prod = PW'(a_i) * PW'(b_i);

`ifdef SIGMOID_BWD_ROUND_EN
    assign prod_adj = prod + (PW'(1) << (FL - 1));
`else
    assign prod_adj = prod;
`endif

    assign p_o              = prod_adj[FL+WIDTH-1:FL];
    assign unused_prod_bits = ^{prod_adj[PW-1:FL+WIDTH], prod_adj[FL-1:0]};

endmodule

// File: rtl/sigmoid_bwd.sv
// Sigmoid backward pass d = g * y * (1 - y) using one time-shared fixed-point multiplier.
// Build with SIGMOID_BWD_ROUND_EN to round both products instead of truncating.
module sigmoid_bwd
    import sigmoid_bwd_pkg::*;
#(
    parameter int unsigned WIDTH = sigmoid_bwd_pkg::WIDTH,
    parameter int unsigned FL    = sigmoid_bwd_pkg::FL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    sigmoid_bwd_if.slave bus_io
);
    localparam logic signed [WIDTH-1:0] One = WIDTH'(1) << FL;

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] om_q, om_d;
    logic signed [WIDTH-1:0] g_q, g_d;
    logic signed [WIDTH-1:0] s_q, s_d;
    logic signed [WIDTH-1:0] d_q, d_d;
    logic                    out_valid_q, out_valid_d;

    logic signed [WIDTH-1:0] y_clamp;
    logic signed [WIDTH-1:0] mul_a, mul_b, mul_p;
    logic                    in_ready;

    // Out-of-range y pins to 0 or ONE so the product y*(1-y) becomes exactly zero.
    always_comb begin
        y_clamp = bus_io.y_in;
        if (bus_io.y_in < 0) begin
            y_clamp = '0;
        end else if (bus_io.y_in > One) begin
            y_clamp = One;
        end
    end

    assign mul_a = (state_q == StMul2) ? s_q : y_q;
    assign mul_b = (state_q == StMul2) ? g_q : om_q;

    sigmoid_bwd_fx_mul #(
        .WIDTH (WIDTH),
        .FL    (FL)
    ) u_fx_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    assign in_ready = en & ((state_q == StIdle) | ((state_q == StOut) & bus_io.out_ready));

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        om_d        = om_q;
        g_d         = g_q;
        s_d         = s_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;

        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        y_d     = y_clamp;
                        om_d    = One - y_clamp;
                        g_d     = bus_io.g_in;
                        state_d = StMul1;
                    end
                end
                StMul1: begin
                    s_d     = mul_p;
                    state_d = StMul2;
                end
                StMul2: begin
                    d_d         = mul_p;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end
                StOut: begin
                    if (bus_io.out_ready) begin
                        out_valid_d = 1'b0;
                        if (bus_io.in_valid) begin
                            y_d     = y_clamp;
                            om_d    = One - y_clamp;
                            g_d     = bus_io.g_in;
                            state_d = StMul1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            y_q         <= '0;
            om_q        <= '0;
            g_q         <= '0;
            s_q         <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            om_q        <= om_d;
            g_q         <= g_d;
            s_q         <= s_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.d_out     = d_q;

endmodule
